ex_muldiv_ctrl: RTL and testbench



---
 rtl/ex_muldiv_ctrl_pkg.sv | 20 ++
 rtl/ex_muldiv_ctrl_muldiv_step.sv | 36 +++
 rtl/ex_muldiv_ctrl.sv | 159 +++++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer.
package ex_muldiv_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    MD_MUL  = 2'b00,
    MD_MULH = 2'b01,
    MD_DIV  = 2'b10,
    MD_REM  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_ctrl_muldiv_step.sv
// One iteration of the muldiv datapath: LSB-first shift-add multiply or restoring divide.
// Accumulator layout: {high word, low word}; operand is multiplicand or divisor.
module ex_muldiv_ctrl_muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_operand,
  input  logic              i_div,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_rem_sh;
  logic [XLEN:0] w_diff;

  always_comb begin
    w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_operand};
    // Remainder shifted left by one, pulling in the next dividend bit.
    w_rem_sh = i_acc[2*XLEN-1:XLEN-1];
    w_diff   = w_rem_sh - {1'b0, i_operand};
    if (i_div) begin
      if (w_diff[XLEN]) begin
        o_acc = {w_rem_sh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
      end else begin
        o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
      end
    end else begin
      if (i_acc[0]) begin
        o_acc = {w_sum, i_acc[XLEN-1:1]};
      end else begin
        o_acc = {1'b0, i_acc[2*XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer for the EX stage: stalls the pipeline while it
// iterates over magnitudes, then sign-fixes and presents one registered result.
module ex_muldiv_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_in,
  input  logic [1:0]      op_in,
  input  logic            signed_in,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic            flush_in,
  output logic            stall_out,
  output logic            done_out,
  output logic [XLEN-1:0] result_out
);
  import ex_muldiv_ctrl_pkg::*;

  localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         r_state, w_state_nxt;
  md_op_e            r_op, w_op_nxt;
  logic              r_signed, w_signed_nxt;
  logic              r_neg, w_neg_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [2*XLEN-1:0] r_acc, w_acc_nxt;
  logic [XLEN-1:0]   r_opnd, w_opnd_nxt;
  logic [XLEN-1:0]   r_result, w_result_nxt;

  logic [2*XLEN-1:0] w_step_acc;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_fix;
  logic [XLEN-1:0]   w_abs_a, w_abs_b;
  logic              w_sa, w_sb, w_apply_neg, w_calc_div;

  ex_muldiv_ctrl_muldiv_step #(
    .XLEN (XLEN)
  ) u_step (
    .i_acc     (r_acc),
    .i_operand (r_opnd),
    .i_div     (w_calc_div),
    .o_acc     (w_step_acc)
  );

  assign w_calc_div = (r_op == MD_DIV) || (r_op == MD_REM);
  assign result_out = r_result;

  // Sign correction of the magnitude result, then word selection.
  always_comb begin
    w_apply_neg = r_signed & r_neg;
    w_prod      = w_apply_neg ? (~r_acc + 1'b1) : r_acc;
    w_quo       = w_apply_neg ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
    w_rem       = w_apply_neg ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
    case (r_op)
      MD_MUL:  w_fix = w_prod[XLEN-1:0];
      MD_MULH: w_fix = w_prod[2*XLEN-1:XLEN];
      MD_DIV:  w_fix = w_quo;
      default: w_fix = w_rem;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_signed_nxt = r_signed;
    w_neg_nxt    = r_neg;
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    w_opnd_nxt   = r_opnd;
    w_result_nxt = r_result;
    stall_out    = 1'b0;
    done_out     = 1'b0;

    w_sa    = signed_in & a_in[XLEN-1];
    w_sb    = signed_in & b_in[XLEN-1];
    w_abs_a = w_sa ? (~a_in + 1'b1) : a_in;
    w_abs_b = w_sb ? (~b_in + 1'b1) : b_in;

    unique case (r_state)
      ST_IDLE: begin
        if (start_in) begin
          stall_out    = 1'b1;
          w_op_nxt     = md_op_e'(op_in);
          w_signed_nxt = signed_in;
          w_cnt_nxt    = '0;
          if (op_in[1]) begin
            w_acc_nxt  = {{XLEN{1'b0}}, w_abs_a};
            w_opnd_nxt = w_abs_b;
            w_neg_nxt  = op_in[0] ? w_sa : (w_sa ^ w_sb);
          end else begin
            w_acc_nxt  = {{XLEN{1'b0}}, w_abs_b};
            w_opnd_nxt = w_abs_a;
            w_neg_nxt  = w_sa ^ w_sb;
          end
          // Divide-by-zero and signed overflow bypass the iteration entirely.
          if (op_in[1] && (b_in == '0)) begin
            w_result_nxt = op_in[0] ? a_in : '1;
            w_state_nxt  = ST_DONE;
          end else if (op_in[1] && signed_in && (a_in == SIGNED_MIN) && (b_in == '1)) begin
            w_result_nxt = op_in[0] ? '0 : SIGNED_MIN;
            w_state_nxt  = ST_DONE;
          end else begin
            w_state_nxt = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        stall_out = 1'b1;
        w_acc_nxt = w_step_acc;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(XLEN - 1)) begin
          w_state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        stall_out    = 1'b1;
        w_result_nxt = w_fix;
        w_state_nxt  = ST_DONE;
      end
      ST_DONE: begin
        done_out    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (flush_in) begin
      w_state_nxt  = ST_IDLE;
      w_result_nxt = r_result;
      stall_out    = 1'b0;
      done_out     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_op     <= MD_MUL;
      r_signed <= 1'b0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_signed <= w_signed_nxt;
      r_neg    <= w_neg_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_opnd   <= w_opnd_nxt;
      r_result <= w_result_nxt;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Bench for ex_muldiv_ctrl: transaction-level reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_ex_muldiv_ctrl;
  import ex_muldiv_ctrl_pkg::*;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        start_in  = 1'b0;
  logic [1:0]  op_in     = 2'b00;
  logic        signed_in = 1'b0;
  logic [31:0] a_in      = 32'h0;
  logic [31:0] b_in      = 32'h0;
  logic        flush_in  = 1'b0;
  logic        stall_out;
  logic        done_out;
  logic [31:0] result_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model state: busy flag, cycle the result must appear, values.
  bit          m_busy    = 1'b0;
  int          m_done_at = 0;
  logic [31:0] m_pend    = 32'h0;
  logic [31:0] m_result  = 32'h0;

  ex_muldiv_ctrl #(
    .XLEN  (32),
    .CNT_W (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_in   (start_in),
    .op_in      (op_in),
    .signed_in  (signed_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .flush_in   (flush_in),
    .stall_out  (stall_out),
    .done_out   (done_out),
    .result_out (result_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model_result(input logic [1:0] op, input logic sg,
                                               input logic [31:0] a, input logic [31:0] b);
    longint      xa;
    longint      xb;
    logic [63:0] p;
    xa = sg ? longint'($signed(a)) : longint'({32'h0, a});
    xb = sg ? longint'($signed(b)) : longint'({32'h0, b});
    if (op == 2'b00) begin
      p = xa * xb;
      return p[31:0];
    end
    if (op == 2'b01) begin
      p = xa * xb;
      return p[63:32];
    end
    if (b == 32'h0) return op[0] ? a : 32'hFFFF_FFFF;
    if (sg && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return op[0] ? 32'h0 : 32'h8000_0000;
    p = op[0] ? (xa % xb) : (xa / xb);
    return p[31:0];
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic sg,
                                    input logic [31:0] a, input logic [31:0] b);
    return op[1] && ((b == 32'h0) || (sg && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy    <= 1'b0;
      m_done_at <= 0;
      m_pend    <= 32'h0;
      m_result  <= 32'h0;
    end else if (m_busy) begin
      if (cyc >= m_done_at) m_result <= m_pend;
      if (flush_in || (cyc >= m_done_at)) m_busy <= 1'b0;
    end else if (start_in && !flush_in) begin
      m_busy    <= 1'b1;
      m_done_at <= cyc + (is_special(op_in, signed_in, a_in, b_in) ? 1 : 34);
      m_pend    <= model_result(op_in, signed_in, a_in, b_in);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic        exp_stall;
    logic        exp_done;
    logic [31:0] exp_res;
    exp_stall = !flush_in && ((!m_busy && start_in) || (m_busy && (cyc < m_done_at)));
    exp_done  = m_busy && (cyc == m_done_at) && !flush_in;
    exp_res   = (m_busy && (cyc >= m_done_at)) ? m_pend : m_result;
    check("model stall_out", 32'(stall_out), 32'(exp_stall));
    check("model done_out", 32'(done_out), 32'(exp_done));
    check("model result_out", result_out, exp_res);
  end

  task automatic wait_done(input int budget, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (done_out) begin
        dcyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (dcyc < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout at cycle %0d: got no done_out within %0d cycles", cyc, budget);
    end
  endtask

  task automatic do_op(input string nm, input logic [1:0] op, input logic sg,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    int s;
    int d;
    @(posedge clk);
    #1;
    op_in     = op;
    signed_in = sg;
    a_in      = a;
    b_in      = b;
    start_in  = 1'b1;
    s         = cyc;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    a_in     = $urandom;
    b_in     = $urandom;
    op_in    = 2'($urandom);
    wait_done(60, d);
    check({nm, " latency"}, d - s, lat);
    check({nm, " result"}, result_out, exp);
  endtask

  initial begin
    int s;
    int d;
    int d2;
    int n_done;

    repeat (2) @(posedge clk);
    #1;
    check("reset result_out", result_out, 32'h0);
    check("reset stall_out", 32'(stall_out), 32'h0);
    check("reset done_out", 32'(done_out), 32'h0);
    rst_n = 1'b1;

    do_op("MUL 7*6", MD_MUL, 1'b0, 32'd7, 32'd6, 32'd42, 34);
    do_op("MULH -1*2", MD_MULH, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34);
    do_op("DIV -7/2", MD_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    do_op("REM -7/2", MD_REM, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    do_op("DIVU 100/7", MD_DIV, 1'b0, 32'd100, 32'd7, 32'd14, 34);
    do_op("REMU 100/7", MD_REM, 1'b0, 32'd100, 32'd7, 32'd2, 34);
    do_op("DIV 5/0", MD_DIV, 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("REM 5/0", MD_REM, 1'b1, 32'd5, 32'd0, 32'd5, 1);
    do_op("DIV ovf", MD_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("REM ovf", MD_REM, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    do_op("DIVU min/max", MD_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34);
    do_op("REMU min/max", MD_REM, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
    do_op("DIV 20/-3", MD_DIV, 1'b1, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 34);
    do_op("REM 20/-3", MD_REM, 1'b1, 32'd20, 32'hFFFF_FFFD, 32'd2, 34);
    do_op("MULHU max*max", MD_MULH, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    do_op("MUL -3*5", MD_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 34);

    // Flush mid-multiply, then restart one cycle later.
    @(posedge clk);
    #1;
    op_in     = MD_MUL;
    signed_in = 1'b0;
    a_in      = 32'd3;
    b_in      = 32'd3;
    start_in  = 1'b1;
    s         = cyc;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    while (cyc < s + 12) begin
      @(posedge clk);
      #1;
    end
    flush_in = 1'b1;
    #1;
    check("flush stall_out", 32'(stall_out), 32'h0);
    @(posedge clk);
    #1;
    flush_in = 1'b0;
    a_in     = 32'd9;
    b_in     = 32'd9;
    start_in = 1'b1;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    n_done   = 0;
    while (cyc < s + 40) begin
      if (done_out) n_done++;
      @(posedge clk);
      #1;
    end
    check("flush no done", n_done, 0);
    check("flush result held", result_out, 32'hFFFF_FFF1);
    wait_done(20, d);
    check("post-flush latency", d - s, 47);
    check("post-flush result", result_out, 32'd81);

    // Asynchronous reset in the middle of an iteration.
    @(posedge clk);
    #1;
    op_in    = MD_MUL;
    a_in     = 32'd4;
    b_in     = 32'd4;
    start_in = 1'b1;
    s        = cyc;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    while (cyc < s + 10) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("mid reset result_out", result_out, 32'h0);
    check("mid reset stall_out", 32'(stall_out), 32'h0);
    check("mid reset done_out", 32'(done_out), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_op("DIVU after reset", MD_DIV, 1'b0, 32'd1000, 32'd10, 32'd100, 34);

    // start held high: the DONE-cycle start is ignored, IDLE accepts the next.
    @(posedge clk);
    #1;
    op_in     = MD_MUL;
    signed_in = 1'b0;
    a_in      = 32'd2;
    b_in      = 32'd3;
    start_in  = 1'b1;
    s         = cyc;
    @(posedge clk);
    #1;
    wait_done(60, d);
    @(posedge clk);
    #1;
    wait_done(60, d2);
    start_in = 1'b0;
    check("b2b first latency", d - s, 34);
    check("b2b interval", d2 - d, 35);
    check("b2b result", result_out, 32'd6);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got no end of stimulus, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
